seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side monitor for the multiplexed 8-digit seven-segment display bus (AN, CA–CG, DP). It samples the scanned anode/segment lines and rebuilds the 8 displayed hex digits and decimal points. It reports each completed frame and classifies frame-to-frame motion as left shift, right shift or static, which lets the enable/dir shifting display be checked in loopback or by a bench.

## Interface
- SETTLE_CYCLES, 4: consecutive identical samples required before a digit is captured (range 1–255).
- STALL_CYCLES, 1048576: cycles without a capture before `stall` asserts.
- sys_clk  in  1  clock, rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- AN  in  8  anodes, active-low; AN[0] is the rightmost digit and AN[7] the leftmost.
- CA, CB, CC, CD, CE, CF, CG  in  1 each  segments, active-low.
- DP  in  1  decimal point, active-low.
- digits  out  32  reconstructed frame; digit i is in digits[4i+3:4i].
- dp_bits  out  8  decimal point per digit, 1 = lit.
- glyph_err  out  8  per digit, 1 = segment pattern not a hex glyph.
- frame_valid  out  1  one-cycle pulse when a new frame is published.
- move_left, move_right, move_none  out  1 each  one-cycle classification pulses, coincident with frame_valid.
- an_err  out  1  level; registered AN has two or more low bits.
- stall  out  1  level; no capture for STALL_CYCLES cycles.

## Operation
- **Input register.** All bus inputs are registered once. All later logic uses the registered copy. Segment vector seg = ~{CG,CF,CE,CD,CC,CB,CA}, bit 0 = CA.
- **Anode select.** The select is valid when exactly one bit of registered AN is low. All-high or multi-low inputs are invalid and clear the settle counter.
- **State machine.**
  - WAIT: on a valid select → SETTLE with cnt=1.
  - SETTLE: while select, seg and DP equal the previous sample, cnt increments. On any difference, cnt restarts at 1, or the machine returns to WAIT if the select is invalid. When cnt reaches SETTLE_CYCLES, the block captures the digit and moves to HOLD.
  - HOLD: no further capture until the select or seg/DP changes → WAIT.
- **Capture.** Decode seg to a nibble and write it into working slot i, together with the DP bit and the glyph error bit. Set mask bit i. A repeat capture of slot i within a frame overwrites the slot.
- **Glyph table.** Standard hex, bit 0 = a:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
  - Any other pattern, including blank, decodes to nibble 0 with glyph_err set.
- **Frame publish.** When the mask becomes 8'hFF, the block copies the working slots to digits/dp_bits/glyph_err, asserts frame_valid, and clears the mask in the same cycle.
- **Motion classification.** The new frame N is compared with the previous published frame P, using digits only.
  - N == P → move_none.
  - N == {P[27:0],P[31:28]} (content moves toward AN[7]) → move_left.
  - N == {P[3:0],P[31:4]} → move_right.
  - Otherwise no pulse.
  - Priority is none > left > right, so at most one pulse fires.
  - The first frame after reset produces no move pulse.
- **Stall.** The stall counter resets on every capture and saturates. `stall` = counter ≥ STALL_CYCLES.

## Timing
- Reset values:
  - digits, dp_bits, glyph_err = 0.
  - frame_valid, move_* = 0.
  - an_err = 0, stall = 0.
  - mask = 0, state = WAIT, no previous frame.
- Capture latency: the registered sample that completes SETTLE_CYCLES identical samples is written at that clock edge. That is SETTLE_CYCLES+1 edges after a stable bus appears.
- Publish latency: frame_valid and the new outputs appear on the edge after the capture that completes the mask.
- an_err follows registered AN with 1 cycle of latency.
- Reset asserted mid-frame discards the working slots, mask and previous frame. The next published frame produces no move pulse.

## Structure
- Package seg_scan_pkg holds:
  - the 16 glyph constants;
  - the state enum (WAIT, SETTLE, HOLD);
  - a function for one-hot-low anode index and validity.
- Sub-module seg7_glyph_decode: combinational, seg[6:0] → {err, nibble[3:0]}.

## Test plan
- **Static scan.** Scan digits 7..0 = "12345678" with DP off, 16 cycles per digit, SETTLE_CYCLES=4. Required: digits=32'h12345678, glyph_err=0, frame_valid once per scan. move_none from the second frame onward; no move pulse on the first frame.
- **Left shift.** Frame 32'h12345678, then frame 32'h23456781. Required: move_left pulse together with the second frame_valid.
- **Right shift.** Frame 32'h12345678, then frame 32'h81234567. Required: move_right pulse only.
- **Glitch and error.** Hold each digit for 3 cycles (less than SETTLE_CYCLES). Required: no capture, frame_valid never pulses, stall asserts after STALL_CYCLES (set to 64). Drive AN=8'hFC. Required: an_err=1 one cycle later, and no capture.
- **Bad glyph.** Drive seg=7'h49 on digit 2. Required: glyph_err=8'h04 and nibble 0 at digits[11:8] on publish.
- **Reset mid-frame.** Pulse sys_rst after 5 digits are captured. Required: all outputs return to 0. The next full scan publishes normally with no move pulse.

Source files
------------

// File: rtl/seg_scan_decoder_pkg.sv
// Shared types and constants for the seven-segment scan decoder:
// glyph patterns, scan state machine encoding and anode helpers.
package seg_scan_pkg;

    // Segment patterns, bit 0 = segment a, 1 = lit.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } an_sel_t;

    // Number of active (low) anode lines.
    function automatic logic [3:0] an_low_count(input logic [7:0] an);
        logic [3:0] lows;
        lows = 4'd0;
        for (int i = 0; i < 8; i++) begin
            lows = lows + {3'd0, ~an[i]};
        end
        return lows;
    endfunction

    // Digit index of a one-hot-low anode vector; valid only if exactly one line is low.
    function automatic an_sel_t anode_decode(input logic [7:0] an);
        an_sel_t r;
        r.valid = (an_low_count(an) == 4'd1);
        r.idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an[i]) begin
                r.idx = 3'(i);
            end else begin
                r.idx = r.idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Multiplexed seven-segment display bus: active-low anodes, segments and DP.
interface seg_scan_decoder_if;
    logic [7:0] AN;
    logic       CA;
    logic       CB;
    logic       CC;
    logic       CD;
    logic       CE;
    logic       CF;
    logic       CG;
    logic       DP;

    // Display driver side.
    modport master (output AN, CA, CB, CC, CD, CE, CF, CG, DP);
    // Monitor side.
    modport slave  (input  AN, CA, CB, CC, CD, CE, CF, CG, DP);
endinterface

// File: rtl/seg_scan_decoder_glyph.sv
// Combinational seven-segment to hex nibble decoder; unknown patterns give 0 + err.
module seg7_glyph_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       err_o
);

    // Table lookup of the lit-segment pattern.
    always_comb begin
        nibble_o = 4'h0;
        err_o    = 1'b0;
        case (seg_i)
            GLYPH_0: nibble_o = 4'h0;
            GLYPH_1: nibble_o = 4'h1;
            GLYPH_2: nibble_o = 4'h2;
            GLYPH_3: nibble_o = 4'h3;
            GLYPH_4: nibble_o = 4'h4;
            GLYPH_5: nibble_o = 4'h5;
            GLYPH_6: nibble_o = 4'h6;
            GLYPH_7: nibble_o = 4'h7;
            GLYPH_8: nibble_o = 4'h8;
            GLYPH_9: nibble_o = 4'h9;
            GLYPH_A: nibble_o = 4'hA;
            GLYPH_B: nibble_o = 4'hB;
            GLYPH_C: nibble_o = 4'hC;
            GLYPH_D: nibble_o = 4'hD;
            GLYPH_E: nibble_o = 4'hE;
            GLYPH_F: nibble_o = 4'hF;
            default: begin
                nibble_o = 4'h0;
                err_o    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side monitor of a scanned 8-digit seven-segment bus. Rebuilds the
// displayed frame, publishes it when every digit has been seen, and classifies
// frame-to-frame motion (static / rotate left / rotate right).
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned STALL_CYCLES  = 1048576
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    seg_scan_decoder_if.slave   bus,
    output logic [31:0]         digits,
    output logic [7:0]          dp_bits,
    output logic [7:0]          glyph_err,
    output logic                frame_valid,
    output logic                move_left,
    output logic                move_right,
    output logic                move_none,
    output logic                an_err,
    output logic                stall
);

    localparam logic [8:0]  SETTLE_W = 9'(SETTLE_CYCLES);
    localparam logic [31:0] STALL_W  = 32'(STALL_CYCLES);

    logic [7:0]  an_q, last_an_q;
    logic [6:0]  seg_q, last_seg_q;
    logic        dp_q, last_dp_q;
    scan_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] slot_nib_q, slot_nib_d;
    logic [7:0]  slot_dp_q, slot_dp_d;
    logic [7:0]  slot_err_q, slot_err_d;
    logic [7:0]  mask_q, mask_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  dp_bits_q, dp_bits_d;
    logic [7:0]  glyph_err_q, glyph_err_d;
    logic        frame_valid_q, frame_valid_d;
    logic        move_left_q, move_left_d;
    logic        move_right_q, move_right_d;
    logic        move_none_q, move_none_d;
    logic        have_prev_q, have_prev_d;
    logic        an_err_q, an_err_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_q, stall_d;

    an_sel_t     sel_s;
    logic        same_s;
    logic        capture_s;
    logic        publish_s;
    logic [8:0]  cnt_inc_s;
    logic [3:0]  dec_nib_s;
    logic        dec_err_s;

    seg7_glyph_decode u_glyph (
        .seg_i    (seg_q),
        .nibble_o (dec_nib_s),
        .err_o    (dec_err_s)
    );

    assign sel_s     = anode_decode(an_q);
    assign same_s    = (an_q == last_an_q) && (seg_q == last_seg_q) && (dp_q == last_dp_q);
    assign cnt_inc_s = {1'b0, cnt_q} + 9'd1;
    assign publish_s = (mask_q == 8'hFF);

    // Register the raw bus (converted to active-high) and keep the previous sample.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            an_q       <= 8'hFF;
            seg_q      <= 7'h00;
            dp_q       <= 1'b0;
            last_an_q  <= 8'hFF;
            last_seg_q <= 7'h00;
            last_dp_q  <= 1'b0;
        end else begin
            an_q       <= bus.AN;
            seg_q      <= ~{bus.CG, bus.CF, bus.CE, bus.CD, bus.CC, bus.CB, bus.CA};
            dp_q       <= ~bus.DP;
            last_an_q  <= an_q;
            last_seg_q <= seg_q;
            last_dp_q  <= dp_q;
        end
    end

    // Settle state machine: capture a digit once it has been stable long enough.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        case (state_q)
            WAIT: begin
                if (sel_s.valid) begin
                    if (SETTLE_W <= 9'd1) begin
                        capture_s = 1'b1;
                        cnt_d     = 8'd0;
                        state_d   = HOLD;
                    end else begin
                        cnt_d     = 8'd1;
                        state_d   = SETTLE;
                    end
                end else begin
                    cnt_d = 8'd0;
                end
            end
            SETTLE: begin
                if (!sel_s.valid) begin
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end else if (same_s) begin
                    if (cnt_inc_s >= SETTLE_W) begin
                        capture_s = 1'b1;
                        cnt_d     = 8'd0;
                        state_d   = HOLD;
                    end else begin
                        cnt_d = cnt_inc_s[7:0];
                    end
                end else begin
                    // A new stable candidate starts counting from this sample.
                    if (SETTLE_W <= 9'd1) begin
                        capture_s = 1'b1;
                        cnt_d     = 8'd0;
                        state_d   = HOLD;
                    end else begin
                        cnt_d = 8'd1;
                    end
                end
            end
            HOLD: begin
                if (!same_s || !sel_s.valid) begin
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end else begin
                    cnt_d = 8'd0;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = WAIT;
            end
        endcase
    end

    // State machine registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= WAIT;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Working slots, frame publish, motion classification and health monitors.
    always_comb begin
        slot_nib_d    = slot_nib_q;
        slot_dp_d     = slot_dp_q;
        slot_err_d    = slot_err_q;
        mask_d        = publish_s ? 8'h00 : mask_q;
        digits_d      = digits_q;
        dp_bits_d     = dp_bits_q;
        glyph_err_d   = glyph_err_q;
        frame_valid_d = publish_s;
        move_left_d   = 1'b0;
        move_right_d  = 1'b0;
        move_none_d   = 1'b0;
        have_prev_d   = have_prev_q | publish_s;
        an_err_d      = (an_low_count(an_q) >= 4'd2);

        if (capture_s) begin
            slot_nib_d[{sel_s.idx, 2'b00} +: 4] = dec_nib_s;
            slot_dp_d[sel_s.idx]                = dp_q;
            slot_err_d[sel_s.idx]               = dec_err_s;
            mask_d[sel_s.idx]                   = 1'b1;
            stall_cnt_d                         = 32'd0;
        end else if (stall_cnt_q >= STALL_W) begin
            stall_cnt_d = stall_cnt_q;
        end else begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        stall_d = (stall_cnt_d >= STALL_W);

        if (publish_s) begin
            digits_d    = slot_nib_q;
            dp_bits_d   = slot_dp_q;
            glyph_err_d = slot_err_q;
            // digits_q still holds the previous published frame here.
            if (have_prev_q) begin
                move_none_d  = (slot_nib_q == digits_q);
                move_left_d  = !move_none_d && (slot_nib_q == {digits_q[27:0], digits_q[31:28]});
                move_right_d = !move_none_d && !move_left_d &&
                               (slot_nib_q == {digits_q[3:0], digits_q[31:4]});
            end else begin
                move_none_d = 1'b0;
            end
        end else begin
            digits_d = digits_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            slot_nib_q    <= 32'd0;
            slot_dp_q     <= 8'd0;
            slot_err_q    <= 8'd0;
            mask_q        <= 8'd0;
            digits_q      <= 32'd0;
            dp_bits_q     <= 8'd0;
            glyph_err_q   <= 8'd0;
            frame_valid_q <= 1'b0;
            move_left_q   <= 1'b0;
            move_right_q  <= 1'b0;
            move_none_q   <= 1'b0;
            have_prev_q   <= 1'b0;
            an_err_q      <= 1'b0;
            stall_cnt_q   <= 32'd0;
            stall_q       <= 1'b0;
        end else begin
            slot_nib_q    <= slot_nib_d;
            slot_dp_q     <= slot_dp_d;
            slot_err_q    <= slot_err_d;
            mask_q        <= mask_d;
            digits_q      <= digits_d;
            dp_bits_q     <= dp_bits_d;
            glyph_err_q   <= glyph_err_d;
            frame_valid_q <= frame_valid_d;
            move_left_q   <= move_left_d;
            move_right_q  <= move_right_d;
            move_none_q   <= move_none_d;
            have_prev_q   <= have_prev_d;
            an_err_q      <= an_err_d;
            stall_cnt_q   <= stall_cnt_d;
            stall_q       <= stall_d;
        end
    end

    assign digits      = digits_q;
    assign dp_bits     = dp_bits_q;
    assign glyph_err   = glyph_err_q;
    assign frame_valid = frame_valid_q;
    assign move_left   = move_left_q;
    assign move_right  = move_right_q;
    assign move_none   = move_none_q;
    assign an_err      = an_err_q;
    assign stall       = stall_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: full scans push the expected frame,
// a monitor pops and compares on every frame_valid pulse.
module tb_seg_scan_decoder;

    logic        sys_clk;
    logic        sys_rst;
    logic [31:0] digits;
    logic [7:0]  dp_bits;
    logic [7:0]  glyph_err;
    logic        frame_valid;
    logic        move_left;
    logic        move_right;
    logic        move_none;
    logic        an_err;
    logic        stall;

    seg_scan_decoder_if bus_if ();

    seg_scan_decoder #(
        .SETTLE_CYCLES (4),
        .STALL_CYCLES  (64)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .bus         (bus_if),
        .digits      (digits),
        .dp_bits     (dp_bits),
        .glyph_err   (glyph_err),
        .frame_valid (frame_valid),
        .move_left   (move_left),
        .move_right  (move_right),
        .move_none   (move_none),
        .an_err      (an_err),
        .stall       (stall)
    );

    typedef struct {
        logic [31:0] d;
        logic [7:0]  dp;
        logic [7:0]  err;
        logic [2:0]  mv;   // {left, right, none}
    } exp_t;

    exp_t        sb_q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          frame_cnt = 0;
    logic [31:0] prev_d;
    bit          have_prev = 1'b0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic drive_digit(input int idx, input logic [6:0] seg, input logic dp, input int cycles);
        logic [7:0] one;
        one = 8'd1;
        bus_if.AN = ~(one << idx);
        {bus_if.CG, bus_if.CF, bus_if.CE, bus_if.CD, bus_if.CC, bus_if.CB, bus_if.CA} = ~seg;
        bus_if.DP = ~dp;
        repeat (cycles) @(posedge sys_clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.AN = 8'hFF;
        {bus_if.CG, bus_if.CF, bus_if.CE, bus_if.CD, bus_if.CC, bus_if.CB, bus_if.CA} = 7'h7F;
        bus_if.DP = 1'b1;
    endtask

    // Full scan 7..0; bad_idx < 8 puts the non-glyph 7'h49 on that digit.
    task automatic scan(input logic [31:0] val, input logic [7:0] dp, input int bad_idx);
        exp_t e;
        e.d   = val;
        e.dp  = dp;
        e.err = 8'h00;
        if (bad_idx < 8) begin
            e.d[bad_idx*4 +: 4] = 4'h0;
            e.err[bad_idx]      = 1'b1;
        end
        e.mv = 3'b000;
        if (have_prev) begin
            if (e.d == prev_d)                              e.mv = 3'b001;
            else if (e.d == {prev_d[27:0], prev_d[31:28]})  e.mv = 3'b100;
            else if (e.d == {prev_d[3:0], prev_d[31:4]})    e.mv = 3'b010;
        end
        prev_d    = e.d;
        have_prev = 1'b1;
        sb_q.push_back(e);
        for (int k = 7; k >= 0; k--) begin
            drive_digit(k, (k == bad_idx) ? 7'h49 : glyph(val[k*4 +: 4]), dp[k], 16);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_digits"}, digits, 32'd0);
        chk({tag, "_flags"}, {dp_bits, glyph_err}, 32'd0);
        chk({tag, "_pulses"}, {frame_valid, move_left, move_right, move_none, an_err, stall}, 32'd0);
    endtask

    // Scoreboard monitor: compare each published frame against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (frame_valid) begin
                frame_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", digits, 32'hFFFFFFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("frame_digits", digits, e.d);
                    chk("frame_dp", {24'd0, dp_bits}, {24'd0, e.dp});
                    chk("frame_glyph_err", {24'd0, glyph_err}, {24'd0, e.err});
                    chk("frame_move", {29'd0, move_left, move_right, move_none}, {29'd0, e.mv});
                end
            end else if (move_left | move_right | move_none) begin
                chk("stray_move", {29'd0, move_left, move_right, move_none}, 32'd0);
            end
        end
    end

    initial begin
        int snap;
        sys_rst = 1'b1;
        bus_idle();
        repeat (3) @(posedge sys_clk);
        #1;
        check_all_zero("reset");
        sys_rst = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;

        // Static frames, then left and right rotations, then DP-only change.
        scan(32'h12345678, 8'h00, 8);
        scan(32'h12345678, 8'h00, 8);
        scan(32'h12345678, 8'h00, 8);
        chk("static_frame_count", frame_cnt, 3);
        scan(32'h23456781, 8'h00, 8);
        scan(32'h12345678, 8'h00, 8);
        scan(32'h81234567, 8'h00, 8);
        scan(32'h9ABCDEF0, 8'h00, 8);
        scan(32'h9ABCDEF0, 8'hA5, 8);

        // Glitchy scan: each digit too short to settle.
        chk("stall_before_glitch", {31'd0, stall}, 32'd0);
        snap = frame_cnt;
        for (int r = 0; r < 4; r++) begin
            for (int k = 7; k >= 0; k--) begin
                drive_digit(k, glyph(4'(k)), 1'b0, 3);
            end
        end
        chk("glitch_no_frame", frame_cnt, snap);
        chk("stall_after_glitch", {31'd0, stall}, 32'd1);

        // Two anodes low at once.
        bus_if.AN = 8'hFC;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("an_err_set", {31'd0, an_err}, 32'd1);
        repeat (10) @(posedge sys_clk);
        #1;
        chk("an_err_no_capture", {31'd0, stall}, 32'd1);
        bus_idle();
        repeat (3) @(posedge sys_clk);
        #1;
        chk("an_err_clear", {31'd0, an_err}, 32'd0);

        // Non-glyph pattern on digit 2.
        scan(32'h13572468, 8'h00, 2);
        chk("stall_cleared", {31'd0, stall}, 32'd0);

        // Reset after five digits of a new frame.
        for (int k = 7; k >= 3; k--) begin
            drive_digit(k, glyph(4'(k)), 1'b0, 16);
        end
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check_all_zero("midreset");
        sys_rst   = 1'b0;
        have_prev = 1'b0;
        snap      = frame_cnt;
        scan(32'hFEDCBA98, 8'h0F, 8);
        scan(32'hFEDCBA98, 8'h0F, 8);
        bus_idle();

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) begin
            @(posedge sys_clk);
            #1;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("post_reset_frames", frame_cnt - snap, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
